bram_burst_ctrl: RTL and testbench

Initiator-side controller for the single-port block RAM. It drives en/we/addr/din and consumes dout. It turns one burst command (read or write, base address, length) into a run of sequential word accesses. Host-facing write and read data move over valid/ready streams, and the BRAM's one-cycle read latency is absorbed internally so reads run at full throughput under backpressure.

---
 rtl/bram_ctrl_pkg.sv | 13 +
 rtl/rd_skid_fifo.sv | 35 +++
 rtl/bram_burst_ctrl.sv | 128 ++++++++++++
 tb/tb_bram_burst_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bram_ctrl_pkg.sv
// Shared constants and FSM encoding for the BRAM burst controller and its BRAM.
package bram_ctrl_pkg;
    localparam int DEF_W_DATA = 32;
    localparam int DEF_W_WORD = 4;
    localparam int DEF_N_WORD = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry registered read-data FIFO; push and pop may coincide.
module rd_skid_fifo #(
    parameter int W_DATA = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [W_DATA-1:0] din,
    input  logic              pop,
    output logic [W_DATA-1:0] dout,
    output logic [1:0]        cnt
);
    logic [W_DATA-1:0] mem [2];
    logic              wr_ptr, rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

    assign dout = mem[rd_ptr];
endmodule

// File: rtl/bram_burst_ctrl.sv
// Burst controller: one command becomes a run of sequential BRAM word accesses,
// with read latency absorbed by a 2-deep FIFO so reads stream under backpressure.
module bram_burst_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int W_DATA = DEF_W_DATA,
    parameter int N_WORD = DEF_N_WORD,
    parameter int W_WORD = DEF_W_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [W_WORD-1:0] cmd_addr,
    input  logic [W_WORD:0]   cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [W_DATA-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [W_DATA-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              bram_en,
    output logic              bram_we,
    output logic [W_WORD-1:0] bram_addr,
    output logic [W_DATA-1:0] bram_din,
    input  logic [W_DATA-1:0] bram_dout
);
    state_t              state_q, state_d;
    logic [W_WORD-1:0]   addr_q, addr_nxt;
    logic [W_WORD:0]     rem_q;
    logic                inflight_q;
    logic                accept, wr_fire, issue, pop;
    logic [1:0]          fifo_cnt;
    logic [2:0]          occ;
    logic [W_DATA-1:0]   fifo_dout;

    rd_skid_fifo #(.W_DATA(W_DATA)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (inflight_q),
        .din  (bram_dout),
        .pop  (pop),
        .dout (fifo_dout),
        .cnt  (fifo_cnt)
    );

    // Outputs are gated by rst so they read as reset values during the reset cycle itself
    assign rd_valid = !rst && (fifo_cnt != 2'd0);
    assign rd_data  = rst ? '0 : fifo_dout;
    assign pop      = rd_valid && rd_ready;
    assign busy     = !rst && (state_q != IDLE);
    // Occupancy the FIFO will reach once the in-flight word lands
    assign occ      = 3'(fifo_cnt) + 3'(inflight_q) - 3'(pop);
    assign addr_nxt = (addr_q == W_WORD'(N_WORD - 1)) ? '0 : addr_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        done      = 1'b0;
        bram_en   = 1'b0;
        bram_we   = 1'b0;
        bram_addr = '0;
        bram_din  = '0;
        accept    = 1'b0;
        wr_fire   = 1'b0;
        issue     = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        accept  = 1'b1;
                        state_d = (cmd_len == '0) ? DONE : (cmd_write ? WRITE : READ);
                    end
                end
                WRITE: begin
                    wr_ready = (rem_q != '0);
                    if (wr_valid && wr_ready) begin
                        wr_fire   = 1'b1;
                        bram_en   = 1'b1;
                        bram_we   = 1'b1;
                        bram_addr = addr_q;
                        bram_din  = wr_data;
                        if (rem_q == (W_WORD+1)'(1))
                            state_d = DONE;
                    end
                end
                READ: begin
                    issue = (rem_q != '0) && (occ < 3'd2);
                    if (issue) begin
                        bram_en   = 1'b1;
                        bram_addr = addr_q;
                    end
                    if (rem_q == '0 && !inflight_q && fifo_cnt == {1'b0, pop})
                        state_d = DONE;
                end
                DONE: begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (accept) begin
                addr_q <= cmd_addr;
                rem_q  <= cmd_len;
            end else if (wr_fire || issue) begin
                addr_q <= addr_nxt;
                rem_q  <= rem_q - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bram_burst_ctrl.sv
// Directed bench for bram_burst_ctrl with a behavioural 16x32 BRAM attached.
module tb_bram_burst_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_addr;
    logic [4:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic        busy, done;
    logic        bram_en, bram_we;
    logic [3:0]  bram_addr;
    logic [31:0] bram_din;
    logic [31:0] bram_dout;

    logic [31:0] mem [16];
    int          checks = 0;
    int          errors = 0;
    int          we_cnt = 0, en_cnt = 0, done_cnt = 0, max_cnt = 0;

    always #5 clk = ~clk;

    bram_burst_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout)
    );

    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_din;
            else         bram_dout      <= mem[bram_addr];
        end
        if (bram_en && bram_we) we_cnt <= we_cnt + 1;
        if (bram_en)            en_cnt <= en_cnt + 1;
        if (done)               done_cnt <= done_cnt + 1;
        if (int'(dut.fifo_cnt) > max_cnt) max_cnt <= int'(dut.fifo_cnt);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] a_w(input int i); return 32'hA0A0_0000 + 32'(i); endfunction
    function automatic logic [31:0] b_w(input int i); return 32'hB0B0_0000 + 32'(i); endfunction
    function automatic logic [31:0] c_w(input int i); return 32'hC0C0_0000 + 32'(i); endfunction

    initial begin
        int snap_we, snap_en, snap_done, n;
        logic [31:0] got [8];
        logic [31:0] exp_bp [8];
        logic got_done;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        bram_dout = '0;
        rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 0; wr_data = '0; rd_ready = 0;

        // Reset values
        @(negedge clk); @(negedge clk); #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_bram_en", 32'(bram_en), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", rd_data, 0);
        @(negedge clk); rst = 1'b0; #1;
        chk("idle_cmd_ready", 32'(cmd_ready), 1);

        // Write burst addr=2 len=4
        snap_we = we_cnt; snap_done = done_cnt;
        @(negedge clk); cmd_valid = 1; cmd_write = 1; cmd_addr = 4'd2; cmd_len = 5'd4; #1;
        chk("wr_accept", 32'(cmd_ready), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); cmd_valid = 0; wr_valid = 1; wr_data = a_w(i); #1;
            chk("wr_we", 32'(bram_we), 1);
            chk("wr_addr", 32'(bram_addr), 32'(2 + i));
            chk("wr_din", bram_din, a_w(i));
        end
        @(negedge clk); wr_valid = 0; #1;
        chk("wr_done", 32'(done), 1);
        chk("wr_done_busy", 32'(busy), 1);
        @(negedge clk); #1;
        chk("wr_busy_fall", 32'(busy), 0);
        chk("wr_we_count", 32'(we_cnt - snap_we), 4);
        chk("wr_done_count", 32'(done_cnt - snap_done), 1);
        for (int i = 0; i < 4; i++) chk("wr_mem", mem[2 + i], a_w(i));

        // Full-rate read-back addr=2 len=4
        @(negedge clk); cmd_valid = 1; cmd_write = 0; cmd_addr = 4'd2; cmd_len = 5'd4; rd_ready = 1; #1;
        chk("rd_accept", 32'(cmd_ready), 1);
        @(negedge clk); cmd_valid = 0; #1;
        chk("rd_issue_en", 32'(bram_en), 1);
        chk("rd_issue_addr", 32'(bram_addr), 2);
        chk("rd_c1_valid", 32'(rd_valid), 0);
        @(negedge clk); #1;
        chk("rd_c2_valid", 32'(rd_valid), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("rd_valid", 32'(rd_valid), 1);
            chk("rd_data", rd_data, a_w(i));
        end
        @(negedge clk); #1;
        chk("rd_done", 32'(done), 1);
        chk("rd_done_valid", 32'(rd_valid), 0);

        // Wrap-around write addr=14 len=4
        @(negedge clk); cmd_valid = 1; cmd_write = 1; cmd_addr = 4'd14; cmd_len = 5'd4; rd_ready = 0; #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); cmd_valid = 0; wr_valid = 1; wr_data = b_w(i); #1;
            chk("wrap_addr", 32'(bram_addr), 32'((14 + i) % 16));
        end
        @(negedge clk); wr_valid = 0; #1;
        chk("wrap_done", 32'(done), 1);
        chk("wrap_mem15", mem[15], b_w(1));
        chk("wrap_mem0", mem[0], b_w(2));

        // Backpressure read addr=14 len=8, rd_ready pattern 1,0,0,1
        for (int i = 0; i < 4; i++) begin exp_bp[i] = b_w(i); exp_bp[i + 4] = a_w(i); end
        for (int i = 0; i < 8; i++) got[i] = '0;
        n = 0; got_done = 0;
        @(negedge clk); #1;
        for (int cyc = 0; cyc < 60 && !got_done; cyc++) begin
            @(negedge clk);
            cmd_valid = (cyc == 0); cmd_write = 0; cmd_addr = 4'd14; cmd_len = 5'd8;
            rd_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            #1;
            if (rd_valid && rd_ready) begin
                if (n < 8) got[n] = rd_data;
                n++;
            end
            if (done) got_done = 1;
        end
        cmd_valid = 0;
        chk("bp_done_seen", 32'(got_done), 1);
        chk("bp_beats", 32'(n), 8);
        for (int i = 0; i < 8; i++) chk("bp_data", got[i], exp_bp[i]);
        chk("bp_fifo_max_le2", 32'(max_cnt <= 2), 1);

        // len=0 command
        @(negedge clk); rd_ready = 0; #1;
        snap_en = en_cnt;
        @(negedge clk); cmd_valid = 1; cmd_write = 0; cmd_addr = 4'd3; cmd_len = 5'd0; #1;
        chk("len0_accept", 32'(cmd_ready), 1);
        @(negedge clk); cmd_valid = 0; #1;
        chk("len0_done", 32'(done), 1);
        @(negedge clk); #1;
        chk("len0_idle", 32'(busy), 0);
        chk("len0_no_en", 32'(en_cnt - snap_en), 0);

        // Busy rejection: stalled write addr=6 len=3, foreign command pulsed mid-burst
        @(negedge clk); cmd_valid = 1; cmd_write = 1; cmd_addr = 4'd6; cmd_len = 5'd3; #1;
        @(negedge clk); cmd_valid = 0; #1;
        @(negedge clk); cmd_valid = 1; cmd_write = 0; cmd_addr = 4'd0; cmd_len = 5'd5; #1;
        chk("busy_cmd_ready", 32'(cmd_ready), 0);
        chk("busy_wr_ready", 32'(wr_ready), 1);
        @(negedge clk); cmd_valid = 0; #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); wr_valid = 1; wr_data = c_w(i); #1;
            chk("busy_wr_addr", 32'(bram_addr), 32'(6 + i));
        end
        @(negedge clk); wr_valid = 0; #1;
        chk("busy_done", 32'(done), 1);
        chk("busy_mem8", mem[8], c_w(2));

        // Reset mid-read: read addr=14 len=6, reset after two beats
        @(negedge clk); #1;
        snap_done = done_cnt;
        @(negedge clk); cmd_valid = 1; cmd_write = 0; cmd_addr = 4'd14; cmd_len = 5'd6; rd_ready = 1; #1;
        @(negedge clk); cmd_valid = 0; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("mid_beat0", rd_data, b_w(0));
        @(negedge clk); #1;
        chk("mid_beat1", rd_data, b_w(1));
        @(negedge clk); rst = 1; #1;
        chk("mid_rst_rd_valid", 32'(rd_valid), 0);
        chk("mid_rst_rd_data", rd_data, 0);
        chk("mid_rst_bram_en", 32'(bram_en), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 0);
        @(negedge clk); rst = 0; #1;
        chk("mid_post_rd_valid", 32'(rd_valid), 0);
        chk("mid_post_cmd_ready", 32'(cmd_ready), 1);
        chk("mid_no_done", 32'(done_cnt - snap_done), 0);
        @(negedge clk); cmd_valid = 1; cmd_write = 0; cmd_addr = 4'd2; cmd_len = 5'd2; #1;
        @(negedge clk); cmd_valid = 0; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("post_rst_beat0", rd_data, a_w(0));
        chk("post_rst_valid0", 32'(rd_valid), 1);
        @(negedge clk); #1;
        chk("post_rst_beat1", rd_data, a_w(1));
        @(negedge clk); #1;
        chk("post_rst_done", 32'(done), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
